// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled counter bank: overflow mode encodings
// and the all-ones limit used by each channel's count step.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // All-ones value of a w-bit counter, right-aligned in 64 bits (w in 1..64).
  function automatic logic [63:0] cnt_max(input int unsigned w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: prescaler, count register with wrap/saturate overflow
// handling, and a sticky overflow flag.
module counter_channel
  import counter_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int PRE_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ev,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [PRE_W-1:0] cfg_div,
  input  logic             cfg_sat,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [63:0]      CNT_MAX_FULL = cnt_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_MAX_FULL[CNT_W-1:0];

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] div;
  logic             sat;

  // Next count for one step; at the limit it either holds or rolls to zero.
  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] c,
                                                input logic             mode);
    if (c != CNT_MAX)
      return c + CNT_W'(1);
    else if (mode == MODE_SAT)
      return CNT_MAX;
    else
      return '0;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
      pre <= '0;
      div <= '0;
      sat <= MODE_WRAP;
      ovf <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
        pre <= '0;
        ovf <= 1'b0;
      end
      // A config write restarts the prescaler and swallows any same-cycle event.
      if (cfg_we) begin
        div <= cfg_div;
        sat <= cfg_sat;
        pre <= '0;
      end else if (ev && !clr) begin
        if (pre != div) begin
          pre <= pre + PRE_W'(1);
        end else begin
          pre <= '0;
          cnt <= step_cnt(cnt, sat);
          if (cnt == CNT_MAX)
            ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prescaled_counter_bank.sv
// Bank of NUM_CH prescaled event counters; decodes the event/clear select and
// the configuration address into per-channel strobes.
module prescaled_counter_bank
  import counter_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 64,
  parameter  int PRE_W  = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    En,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    Clr,
  input  logic                    Cfg_we,
  input  logic [SEL_W-1:0]        Cfg_ch,
  input  logic [PRE_W-1:0]        Cfg_div,
  input  logic                    Cfg_sat,
  output logic [NUM_CH*CNT_W-1:0] Count,
  output logic [NUM_CH-1:0]       Ovf
);

  // Indices at or above NUM_CH match no channel, so they are silently ignored.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

    logic             ch_ev;
    logic             ch_clr;
    logic             ch_cfg_we;
    logic [CNT_W-1:0] ch_cnt;
    logic             ch_ovf;

    assign ch_ev     = En && (Sel == IDX);
    assign ch_clr    = Clr && (Sel == IDX);
    assign ch_cfg_we = Cfg_we && (Cfg_ch == IDX);

    counter_channel #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
    ) u_ch (
      .Clk     (Clk),
      .Reset   (Reset),
      .ev      (ch_ev),
      .clr     (ch_clr),
      .cfg_we  (ch_cfg_we),
      .cfg_div (Cfg_div),
      .cfg_sat (Cfg_sat),
      .cnt     (ch_cnt),
      .ovf     (ch_ovf)
    );

    assign Count[i*CNT_W +: CNT_W] = ch_cnt;
    assign Ovf[i]                  = ch_ovf;
  end

endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Directed bench: a 4-channel 4-bit bank for counting, prescale, overflow,
// priority and async reset, plus a 3-channel bank for out-of-range selects.
module tb_prescaled_counter_bank;
  import counter_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        En = 1'b0, Clr = 1'b0, Cfg_we = 1'b0, Cfg_sat = 1'b0;
  logic [1:0]  Sel = '0, Cfg_ch = '0;
  logic [3:0]  Cfg_div = '0;
  logic [15:0] Count;
  logic [3:0]  Ovf;

  logic        en_b = 1'b0, clr_b = 1'b0, cfg_we_b = 1'b0, cfg_sat_b = 1'b0;
  logic [1:0]  sel_b = '0, cfg_ch_b = '0;
  logic [3:0]  cfg_div_b = '0;
  logic [23:0] count_b;
  logic [2:0]  ovf_b;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  prescaled_counter_bank #(.NUM_CH(4), .CNT_W(4), .PRE_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel), .Clr(Clr),
    .Cfg_we(Cfg_we), .Cfg_ch(Cfg_ch), .Cfg_div(Cfg_div), .Cfg_sat(Cfg_sat),
    .Count(Count), .Ovf(Ovf)
  );

  prescaled_counter_bank #(.NUM_CH(3), .CNT_W(8), .PRE_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .En(en_b), .Sel(sel_b), .Clr(clr_b),
    .Cfg_we(cfg_we_b), .Cfg_ch(cfg_ch_b), .Cfg_div(cfg_div_b), .Cfg_sat(cfg_sat_b),
    .Count(count_b), .Ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic events(input logic [1:0] ch, input int n);
    for (int k = 0; k < n; k++) begin
      En = 1'b1; Sel = ch;
      tick();
    end
    En = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [3:0] dv, input logic mode);
    Cfg_we = 1'b1; Cfg_ch = ch; Cfg_div = dv; Cfg_sat = mode;
    tick();
    Cfg_we = 1'b0;
  endtask

  initial begin
    #1 Reset = 1'b1;
    tick(); tick();
    chk("reset_count", 64'(Count), 64'h0);
    chk("reset_ovf", 64'(Ovf), 64'h0);
    chk("reset_count_b", 64'(count_b), 64'h0);
    Reset = 1'b0;

    events(2'd0, 5);
    chk("direct_count", 64'(Count), 64'h0005);
    chk("direct_ovf", 64'(Ovf), 64'h0);

    cfg(2'd1, 4'd3, MODE_WRAP);
    events(2'd1, 10);
    chk("prescale_10", 64'(Count), 64'h0025);
    events(2'd1, 2);
    chk("prescale_12", 64'(Count), 64'h0035);

    events(2'd2, 17);
    chk("wrap_count", 64'(Count), 64'h0135);
    chk("wrap_ovf", 64'(Ovf), 64'h4);

    cfg(2'd3, 4'd0, MODE_SAT);
    events(2'd3, 17);
    chk("sat_count", 64'(Count), 64'hF135);
    chk("sat_ovf", 64'(Ovf), 64'hC);

    // Clr, Cfg_we and En together on ch1: cleared, div set to 0, event dropped.
    Clr = 1'b1; En = 1'b1; Sel = 2'd1;
    Cfg_we = 1'b1; Cfg_ch = 2'd1; Cfg_div = 4'd0; Cfg_sat = MODE_WRAP;
    tick();
    Clr = 1'b0; En = 1'b0; Cfg_we = 1'b0;
    chk("prio_all_ch1", 64'(Count), 64'hF105);
    events(2'd1, 1);
    chk("prio_new_div", 64'(Count), 64'hF115);

    // Clr ch0 alongside a config write to ch2 (div=1).
    Clr = 1'b1; Sel = 2'd0;
    Cfg_we = 1'b1; Cfg_ch = 2'd2; Cfg_div = 4'd1; Cfg_sat = MODE_WRAP;
    tick();
    Clr = 1'b0; Cfg_we = 1'b0;
    chk("clr_and_cfg", 64'(Count), 64'hF110);
    events(2'd2, 1);
    chk("cfg_div1_first", 64'(Count), 64'hF110);
    events(2'd2, 1);
    chk("cfg_div1_second", 64'(Count), 64'hF210);
    chk("cfg_keeps_ovf", 64'(Ovf), 64'hC);

    Clr = 1'b1; Sel = 2'd3;
    tick();
    Clr = 1'b0;
    chk("clr_ovf_count", 64'(Count), 64'h0210);
    chk("clr_ovf_flag", 64'(Ovf), 64'h4);

    // Out-of-range select on the 3-channel bank.
    for (int k = 0; k < 4; k++) begin
      en_b = 1'b1; sel_b = 2'd3; clr_b = 1'b0;
      tick();
    end
    cfg_we_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 4'd5;
    tick();
    cfg_we_b = 1'b0;
    chk("oor_count", 64'(count_b), 64'h0);
    chk("oor_ovf", 64'(ovf_b), 64'h0);
    sel_b = 2'd2;
    tick();
    en_b = 1'b0;
    chk("inrange_b", 64'(count_b), 64'h010000);

    // Async reset pulse between edges with ch0 at 7.
    events(2'd0, 7);
    chk("pre_reset_count", 64'(Count), 64'h0217);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_count", 64'(Count), 64'h0);
    chk("async_reset_ovf", 64'(Ovf), 64'h0);
    Reset = 1'b0;
    events(2'd2, 1);
    chk("reset_div_cleared", 64'(Count), 64'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_counter_bank.md
# prescaled_counter_bank

Parametrised bank of NUM_CH independent event counters, each with a programmable prescaler, overflow mode and sticky overflow flag. One event per cycle is steered to a channel by a select index. This generalises the two-channel fixed ratio counter (direct count plus divide-by-4) into a configurable peripheral. It sits beside the other count/statistics blocks in the pre-lab design.

## Interface
- NUM_CH, 4: number of channels, 1..16.
- CNT_W, 64: counter width per channel, 2..64.
- PRE_W, 4: prescaler divider width. The divide ratio is div+1.
- SEL_W, $clog2(NUM_CH) (minimum 1): channel index width. This is derived and is not overridden.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  event strobe for channel Sel.
- Sel  in  SEL_W  channel selected by En and Clr.
- Clr  in  1  synchronous clear of channel Sel.
- Cfg_we  in  1  configuration write strobe.
- Cfg_ch  in  SEL_W  channel addressed by the configuration write.
- Cfg_div  in  PRE_W  new prescaler divider value.
- Cfg_sat  in  1  new mode: 1 = saturate, 0 = wrap.
- Count  out  NUM_CH*CNT_W  packed counts. Channel i occupies bits [i*CNT_W +: CNT_W].
- Ovf  out  NUM_CH  sticky overflow flag per channel.

## Operation
Per-channel state:
- cnt (CNT_W)
- pre (PRE_W)
- div (PRE_W)
- sat (1 bit)
- ovf (1 bit)

Reset, asynchronous: every channel goes to cnt=0, pre=0, div=0, sat=0, ovf=0. All outputs therefore read 0 while Reset is high and immediately after it.

Per cycle, for channel i, priority high to low:
1. **Clr with Sel==i:** cnt←0, pre←0, ovf←0. div and sat are unchanged.
2. **Cfg_we with Cfg_ch==i:** div←Cfg_div, sat←Cfg_sat, pre←0. An En event to the same channel in the same cycle is dropped.
3. **En with Sel==i:**
   - If pre != div: pre←pre+1.
   - Else: pre←0 and the channel takes a count step.

Count step:
- cnt < max (all ones): cnt←cnt+1.
- cnt == max, wrap mode: cnt←0, ovf←1.
- cnt == max, saturate mode: cnt holds max, ovf←1.

Once set, ovf stays 1 until Clr or Reset.

Other rules:
- Clr and Cfg_we may address different channels in the same cycle; both take effect.
- If Clr and Cfg_we address the same channel: Clr's fields are applied, then Cfg's fields (div, sat, pre←0) are applied. The event in that cycle is dropped.
- A Sel or Cfg_ch value ≥ NUM_CH is ignored: no state changes.
- div=0 means every event counts, which is the direct-count behaviour.
- A mode change does not alter cnt or ovf.

## Timing
- All state updates on the rising edge of Clk. Outputs come directly from registers; there is no combinational path from inputs to outputs.
- Latency: an event sampled at edge k is visible on Count after edge k. With div=d, the (d+1)-th accepted event on a channel raises cnt.
- A new div/sat applies to events sampled at the edge after the write edge.
- Reset asserted mid-sequence clears state immediately, without waiting for Clk. The first event is accepted at the first rising edge with Reset low.

## Structure
- Shared package counter_pkg:
  - mode constants MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - function for the max count value of a given width.
- Sub-module counter_channel: one channel's cnt/pre/div/sat/ovf with local strobes ev, clr, cfg_we.
- Top level: decodes Sel and Cfg_ch into one-hot strobes and instantiates NUM_CH channels in a generate loop.

## Test plan
- **Reset and direct count:** NUM_CH=4, hold Reset high, then release. Apply 5 cycles of En with Sel=0 → Count ch0 = 5; other channels 0; Ovf = 4'b0000.
- **Prescale:** write ch1 div=3. Apply 10 events to ch1 → cnt1 = 2 and pre1 = 2. Two more events → cnt1 = 3.
- **Wrap vs saturate:** use CNT_W=4.
  - ch2 in wrap mode, 17 events → cnt2 = 1, Ovf[2] = 1.
  - ch3 in saturate mode, 17 events → cnt3 = 15, Ovf[3] = 1.
- **Priority:**
  - Clr, Cfg_we and En all on ch1 in the same cycle → cnt1 = 0, ovf1 = 0, div updated, the event is dropped.
  - Clr on ch0 while Cfg_we targets ch2 → both take effect.
- **Out-of-range index:** use NUM_CH=3. Events with Sel=3 → no counts or flags change.
- **Async reset mid-run:** pulse Reset between clock edges while ch0 = 7 → Count and Ovf go to 0 before the next edge. Configured div values return to 0.
